// File: rtl/execute_hazard_controller_pkg.sv
// Shared types for the execute-stage hazard controller: stage tags,
// forwarding-select encoding and pipeline stage indices.
package execute_hazard_controller_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK
  } stage_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '0;

  // True when the tagged instruction will write register rs (x0 never counts).
  function automatic logic writes_reg(input stage_tag_t t, input logic [REG_ADDR_W-1:0] rs);
    return t.valid && t.we && (t.rd != '0) && (t.rd == rs);
  endfunction

endpackage

// File: rtl/execute_hazard_controller_if.sv
// Decode/execute/memory handshake bundle between the pipeline (master)
// and the hazard controller (slave).
interface execute_hazard_controller_if
  import execute_hazard_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR = 5,
  parameter int unsigned CNT_W    = 16
);
  logic                id_valid;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic                id_rd_we;
  logic                id_is_load;
  logic [REG_ADDR-1:0] id_rs1;
  logic [REG_ADDR-1:0] id_rs2;
  logic [REG_ADDR-1:0] id_rd;
  logic                ex_branch_taken;
  logic                mem_ready;
  logic                stall_fetch;
  logic                stall_decode;
  logic                flush_decode;
  logic                alu_enable;
  fwd_sel_e            fwd_sel_a;
  fwd_sel_e            fwd_sel_b;
  logic [CNT_W-1:0]    stall_count;

  modport master (
    output id_valid, id_uses_rs1, id_uses_rs2, id_rd_we, id_is_load,
    output id_rs1, id_rs2, id_rd, ex_branch_taken, mem_ready,
    input  stall_fetch, stall_decode, flush_decode, alu_enable,
    input  fwd_sel_a, fwd_sel_b, stall_count
  );

  modport slave (
    input  id_valid, id_uses_rs1, id_uses_rs2, id_rd_we, id_is_load,
    input  id_rs1, id_rs2, id_rd, ex_branch_taken, mem_ready,
    output stall_fetch, stall_decode, flush_decode, alu_enable,
    output fwd_sel_a, fwd_sel_b, stall_count
  );
endinterface

// File: rtl/execute_hazard_controller_fwd_select.sv
// Per-operand forwarding source: the youngest in-flight writer of rs wins.
module fwd_select
  import execute_hazard_controller_pkg::*;
(
  input  logic                  uses,
  input  logic [REG_ADDR_W-1:0] rs,
  input  stage_tag_t            ex_tag,
  input  stage_tag_t            mem_tag,
  output fwd_sel_e              sel
);
  logic unused_load_bits;
  assign unused_load_bits = ex_tag.is_load ^ mem_tag.is_load;

  always_comb begin
    sel = FWD_REG;
    if (uses) begin
      if (writes_reg(ex_tag, rs))       sel = FWD_EXMEM;
      else if (writes_reg(mem_tag, rs)) sel = FWD_MEMWB;
    end
  end
endmodule

// File: rtl/execute_hazard_controller.sv
// Execute-stage hazard controller: tracks EX/MEM/WB destination tags, raises
// load-use stalls and branch flushes, and registers ALU operand forwarding.
module execute_hazard_controller
  import execute_hazard_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR = 5,
  parameter int unsigned CNT_W    = 16
)(
  input logic                   clk,
  input logic                   rst,
  execute_hazard_controller_if.slave bus
);
  stage_tag_t            ex_tag, mem_tag, wb_tag, id_tag;
  fwd_sel_e              fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic [REG_ADDR-1:0]   id_rs1, id_rs2, id_rd;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic                  load_use, flush, lu_stall, stall, ex_accept;
  logic                  unused_tag_bits;

  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;
  assign id_rd  = bus.id_rd;
  assign rs1    = REG_ADDR_W'(id_rs1);
  assign rs2    = REG_ADDR_W'(id_rs2);
  assign id_tag = '{valid: 1'b1, rd: REG_ADDR_W'(id_rd), we: bus.id_rd_we, is_load: bus.id_is_load};

  assign load_use = bus.id_valid && ex_tag.is_load &&
                    ((bus.id_uses_rs1 && writes_reg(ex_tag, rs1)) ||
                     (bus.id_uses_rs2 && writes_reg(ex_tag, rs2)));
  // A taken branch kills the decode instruction, so any load-use it had is moot.
  assign flush     = bus.ex_branch_taken && ex_tag.valid && bus.mem_ready;
  assign lu_stall  = load_use && bus.mem_ready && !flush;
  assign stall     = !bus.mem_ready || lu_stall;
  assign ex_accept = bus.id_valid && !stall && !flush;

  assign bus.stall_fetch  = stall;
  assign bus.stall_decode = stall;
  assign bus.flush_decode = flush;
  assign bus.alu_enable   = ex_tag.valid && bus.mem_ready;
  assign bus.fwd_sel_a    = fwd_a_q;
  assign bus.fwd_sel_b    = fwd_b_q;
  assign bus.stall_count  = stall_cnt_q;

  // WB is kept for pipeline bookkeeping; nothing downstream reads it yet.
  assign unused_tag_bits = ^{wb_tag, mem_tag.is_load};

  fwd_select u_fwd_a (
    .uses    (bus.id_uses_rs1),
    .rs      (rs1),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .sel     (fwd_a_d)
  );

  fwd_select u_fwd_b (
    .uses    (bus.id_uses_rs2),
    .rs      (rs2),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .sel     (fwd_b_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag      <= BUBBLE_TAG;
      mem_tag     <= BUBBLE_TAG;
      wb_tag      <= BUBBLE_TAG;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.mem_ready) begin
        wb_tag  <= mem_tag;
        mem_tag <= ex_tag;
        if (ex_accept) begin
          ex_tag  <= id_tag;
          fwd_a_q <= fwd_a_d;
          fwd_b_q <= fwd_b_d;
        end else begin
          ex_tag  <= BUBBLE_TAG;
          fwd_a_q <= FWD_REG;
          fwd_b_q <= FWD_REG;
        end
      end
    end
  end
endmodule

// File: tb/tb_execute_hazard_controller.sv
// Directed scoreboard bench for execute_hazard_controller: each cycle pushes
// the hand-derived expected outputs, which are popped and compared mid-cycle.
module tb_execute_hazard_controller;
  import execute_hazard_controller_pkg::*;

  typedef struct packed {
    logic       v, u1, u2, we, ld;
    logic [4:0] rd, rs1, rs2;
  } instr_t;

  typedef struct packed {
    logic       st, fl, al;
    logic [1:0] fa, fb;
    logic [2:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  execute_hazard_controller_if #(.REG_ADDR(5), .CNT_W(3)) bus ();

  execute_hazard_controller #(.REG_ADDR(5), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.v = 1'b1; i.u1 = 1'b1; i.u2 = 1'b1; i.we = 1'b1;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t alu1(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i = '0;
    i.v = 1'b1; i.u1 = 1'b1; i.we = 1'b1;
    i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  function automatic instr_t load(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i = '0;
    i.v = 1'b1; i.u1 = 1'b1; i.we = 1'b1; i.ld = 1'b1;
    i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then check at negedge.
  task automatic cyc(input instr_t i, input logic br, input logic mr, input logic r,
                     input logic st, input logic fl, input logic al,
                     input logic [1:0] fa, input logic [1:0] fb, input int cnt);
    exp_t e;
    bus.id_valid        = i.v;
    bus.id_uses_rs1     = i.u1;
    bus.id_uses_rs2     = i.u2;
    bus.id_rd_we        = i.we;
    bus.id_is_load      = i.ld;
    bus.id_rd           = i.rd;
    bus.id_rs1          = i.rs1;
    bus.id_rs2          = i.rs2;
    bus.ex_branch_taken = br;
    bus.mem_ready       = mr;
    rst                 = r;
    exp_q.push_back('{st: st, fl: fl, al: al, fa: fa, fb: fb, cnt: 3'(cnt)});
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq($sformatf("c%0d stall_fetch", cyc_n),  16'(bus.stall_fetch),  16'(e.st));
    check_eq($sformatf("c%0d stall_decode", cyc_n), 16'(bus.stall_decode), 16'(e.st));
    check_eq($sformatf("c%0d flush_decode", cyc_n), 16'(bus.flush_decode), 16'(e.fl));
    check_eq($sformatf("c%0d alu_enable", cyc_n),   16'(bus.alu_enable),   16'(e.al));
    check_eq($sformatf("c%0d fwd_sel_a", cyc_n),    16'(bus.fwd_sel_a),    16'(e.fa));
    check_eq($sformatf("c%0d fwd_sel_b", cyc_n),    16'(bus.fwd_sel_b),    16'(e.fb));
    check_eq($sformatf("c%0d stall_count", cyc_n),  16'(bus.stall_count),  16'(e.cnt));
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.id_valid = 1'b0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.id_rd_we = 1'b0; bus.id_is_load = 1'b0;
    bus.id_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.ex_branch_taken = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // args: instr, br, mr, rst | stall, flush, alu, fa, fb, count
    cyc(nop(),         0, 1, 0,  0, 0, 0, 0, 0, 0);  // post-reset idle

    // EX->EX forward, then MEM->EX forward across one unrelated instruction
    cyc(alu(3, 1, 2),  0, 1, 0,  0, 0, 0, 0, 0, 0);
    cyc(alu(6, 3, 4),  0, 1, 0,  0, 0, 1, 0, 0, 0);
    cyc(nop(),         0, 1, 0,  0, 0, 1, 1, 0, 0);
    cyc(alu(7, 8, 9),  0, 1, 0,  0, 0, 0, 0, 0, 0);
    cyc(alu(10, 11, 12), 0, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc(alu1(13, 7),   0, 1, 0,  0, 0, 1, 0, 0, 0);
    cyc(nop(),         0, 1, 0,  0, 0, 1, 2, 0, 0);
    cyc(nop(),         0, 1, 0,  0, 0, 0, 0, 0, 0);

    // load-use: one stall, bubble, then MEM/WB forward on rs2
    cyc(load(5, 1),    0, 1, 0,  0, 0, 0, 0, 0, 0);
    cyc(alu(14, 2, 5), 0, 1, 0,  1, 0, 1, 0, 0, 0);
    cyc(alu(14, 2, 5), 0, 1, 0,  0, 0, 0, 0, 0, 1);
    cyc(nop(),         0, 1, 0,  0, 0, 1, 0, 2, 1);
    cyc(nop(),         0, 1, 0,  0, 0, 0, 0, 0, 1);

    // load-use coincident with taken branch: flush wins, no stall
    cyc(load(5, 1),    0, 1, 0,  0, 0, 0, 0, 0, 1);
    cyc(alu(14, 2, 5), 1, 1, 0,  0, 1, 1, 0, 0, 1);
    cyc(nop(),         1, 1, 0,  0, 0, 0, 0, 0, 1);  // branch with EX bubble
    cyc(nop(),         0, 1, 0,  0, 0, 0, 0, 0, 1);

    // x0 destination never stalls or forwards
    cyc(load(0, 1),    0, 1, 0,  0, 0, 0, 0, 0, 1);
    cyc(alu(15, 0, 0), 0, 1, 0,  0, 0, 1, 0, 0, 1);
    cyc(alu(16, 0, 0), 0, 1, 0,  0, 0, 1, 0, 0, 1);
    cyc(nop(),         0, 1, 0,  0, 0, 1, 0, 0, 1);
    cyc(nop(),         0, 1, 0,  0, 0, 0, 0, 0, 1);

    // mem_ready low for three cycles: everything frozen, count +3
    cyc(alu(3, 1, 2),  0, 1, 0,  0, 0, 0, 0, 0, 1);
    cyc(alu(4, 3, 3),  0, 1, 0,  0, 0, 1, 0, 0, 1);
    cyc(alu(8, 4, 1),  0, 0, 0,  1, 0, 0, 1, 1, 1);
    cyc(alu(8, 4, 1),  1, 0, 0,  1, 0, 0, 1, 1, 2);
    cyc(alu(8, 4, 1),  0, 0, 0,  1, 0, 0, 1, 1, 3);
    cyc(alu(8, 4, 1),  0, 1, 0,  0, 0, 1, 1, 1, 4);
    cyc(nop(),         0, 1, 0,  0, 0, 1, 1, 0, 4);
    cyc(nop(),         0, 1, 0,  0, 0, 0, 0, 0, 4);

    // reset during a load-use stall: no residue afterwards
    cyc(load(5, 1),    0, 1, 0,  0, 0, 0, 0, 0, 4);
    cyc(alu(14, 2, 5), 0, 1, 1,  1, 0, 1, 0, 0, 4);
    cyc(alu(14, 2, 5), 0, 1, 0,  0, 0, 0, 0, 0, 0);
    cyc(nop(),         0, 1, 0,  0, 0, 1, 0, 0, 0);

    // stall_count saturates at 7 with a 3-bit counter
    for (int i = 0; i < 10; i++)
      cyc(nop(),       0, 0, 0,  1, 0, 0, 0, 0, (i > 7) ? 7 : i);
    cyc(nop(),         0, 1, 0,  0, 0, 0, 0, 0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
